// File: rtl/oven_cook_sequencer.sv
// Microwave cook sequencer: door/start/stop FSM, seconds countdown with
// saturating time programming, and a post-cook bell timer.
module oven_cook_sequencer #(
    parameter int unsigned TW         = 12,
    parameter int unsigned MAX_TIME   = 3599,
    parameter int unsigned STEP       = 30,
    parameter int unsigned BELL_TICKS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          door,
    input  logic          start,
    input  logic          stop,
    input  logic          add_step,
    input  logic          load,
    input  logic [TW-1:0] time_in,
    output logic          heat,
    output logic          light,
    output logic          bell,
    output logic          done,
    output logic [TW-1:0] remaining
);

    localparam int unsigned BW = (BELL_TICKS < 2) ? 1 : $clog2(BELL_TICKS + 1);
    localparam logic [TW-1:0] MAX_T  = TW'(MAX_TIME);
    localparam logic [TW-1:0] STEP_T = TW'(STEP);
    localparam logic [BW-1:0] BELL_T = BW'(BELL_TICKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COOK  = 3'd1,
        S_PAUSE = 3'd2,
        S_BELL  = 3'd3,
        S_OPEN  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] rem_nxt;
    logic [TW-1:0] rem_dec;
    logic [BW-1:0] bell_cnt;
    logic [BW-1:0] bell_nxt;

    // Add STEP with saturation at MAX_TIME; one extra bit so the sum cannot wrap.
    function automatic logic [TW-1:0] sat_add(input logic [TW-1:0] x);
        logic [TW:0] s;
        s = {1'b0, x} + {1'b0, STEP_T};
        return (s >= {1'b0, MAX_T}) ? MAX_T : s[TW-1:0];
    endfunction

    // Next-state and next-count logic.
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        bell_nxt  = bell_cnt;
        rem_dec   = tick ? (remaining - TW'(1)) : remaining;

        unique case (state)
            S_IDLE: begin
                if (door) begin
                    state_nxt = S_OPEN;
                end else if (stop) begin
                    rem_nxt = '0;
                end else if (load) begin
                    rem_nxt = (time_in > MAX_T) ? MAX_T : time_in;
                end else if (add_step) begin
                    rem_nxt = sat_add(remaining);
                end else if (start) begin
                    if (remaining == '0) begin
                        rem_nxt = STEP_T;
                    end
                    state_nxt = S_COOK;
                end
            end
            S_COOK: begin
                if (door) begin
                    state_nxt = S_PAUSE;
                end else if (stop) begin
                    state_nxt = S_IDLE;
                    rem_nxt   = '0;
                end else if (add_step) begin
                    // Added time lands after the decrement and cancels completion at 1 s.
                    rem_nxt = sat_add(rem_dec);
                end else if (tick && remaining == TW'(1)) begin
                    rem_nxt   = '0;
                    state_nxt = S_BELL;
                    bell_nxt  = BELL_T;
                end else begin
                    rem_nxt = rem_dec;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    rem_nxt   = '0;
                    state_nxt = door ? S_OPEN : S_IDLE;
                end else if (!door && start) begin
                    state_nxt = S_COOK;
                end
            end
            S_BELL: begin
                if (door) begin
                    state_nxt = S_OPEN;
                end else if (stop) begin
                    state_nxt = S_IDLE;
                end else if (tick) begin
                    bell_nxt = bell_cnt - BW'(1);
                    if (bell_cnt <= BW'(1)) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_OPEN: begin
                if (!door) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered output decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            bell_cnt  <= '0;
            heat      <= 1'b0;
            light     <= 1'b0;
            bell      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            bell_cnt  <= bell_nxt;
            heat      <= (state_nxt == S_COOK);
            light     <= (state_nxt == S_COOK) || (state_nxt == S_PAUSE) || (state_nxt == S_OPEN);
            bell      <= (state_nxt == S_BELL);
            done      <= (state == S_COOK) && (state_nxt == S_BELL);
        end
    end

endmodule

// File: tb/tb_oven_cook_sequencer.sv
// Bench for oven_cook_sequencer: directed scenarios plus random traffic,
// all checked against a behavioural mode/seconds model.
module tb_oven_cook_sequencer;

    localparam int TW         = 12;
    localparam int MAX_TIME   = 3599;
    localparam int STEP       = 30;
    localparam int BELL_TICKS = 3;

    localparam int M_IDLE  = 0;
    localparam int M_COOK  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_BELL  = 3;
    localparam int M_OPEN  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick, door, start, stop, add_step, load;
    logic [TW-1:0] time_in;
    logic          heat, light, bell, done;
    logic [TW-1:0] remaining;

    int vectors = 0;
    int miscompares = 0;

    int m_mode, m_rem, m_bell, m_done;

    oven_cook_sequencer #(
        .TW(TW), .MAX_TIME(MAX_TIME), .STEP(STEP), .BELL_TICKS(BELL_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .door(door), .start(start),
        .stop(stop), .add_step(add_step), .load(load), .time_in(time_in),
        .heat(heat), .light(light), .bell(bell), .done(done),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_rem  = 0;
        m_bell = 0;
        m_done = 0;
    endtask

    // One clock of behaviour, written from the mode rules with plain integers.
    task automatic model_step();
        int nm;
        int r;
        if (rst) begin
            model_reset();
            return;
        end
        nm = m_mode;
        m_done = 0;
        case (m_mode)
            M_IDLE: begin
                if (door) nm = M_OPEN;
                else if (stop) m_rem = 0;
                else if (load) m_rem = imin(int'(time_in), MAX_TIME);
                else if (add_step) m_rem = imin(m_rem + STEP, MAX_TIME);
                else if (start) begin
                    if (m_rem == 0) m_rem = STEP;
                    nm = M_COOK;
                end
            end
            M_COOK: begin
                if (door) nm = M_PAUSE;
                else if (stop) begin
                    nm = M_IDLE;
                    m_rem = 0;
                end else begin
                    r = m_rem - (tick ? 1 : 0);
                    if (add_step) r = imin(r + STEP, MAX_TIME);
                    else if (r == 0) begin
                        nm = M_BELL;
                        m_bell = BELL_TICKS;
                        m_done = 1;
                    end
                    m_rem = r;
                end
            end
            M_PAUSE: begin
                if (stop) begin
                    m_rem = 0;
                    nm = door ? M_OPEN : M_IDLE;
                end else if (!door && start) nm = M_COOK;
            end
            M_BELL: begin
                if (door) nm = M_OPEN;
                else if (stop) nm = M_IDLE;
                else if (tick) begin
                    m_bell = m_bell - 1;
                    if (m_bell == 0) nm = M_IDLE;
                end
            end
            default: begin
                if (!door) nm = M_IDLE;
            end
        endcase
        m_mode = nm;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".heat"},  32'(heat),  32'(m_mode == M_COOK));
        chk({tag, ".light"}, 32'(light), 32'(m_mode == M_COOK || m_mode == M_PAUSE || m_mode == M_OPEN));
        chk({tag, ".bell"},  32'(bell),  32'(m_mode == M_BELL));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".rem"},   32'(remaining), 32'(m_rem));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        tick = 0; door = 0; start = 0; stop = 0; add_step = 0; load = 0; time_in = '0;
    endtask

    task automatic load_and_start(input int t, input string tag);
        stop = 1; cycle({tag, ".stop"}); stop = 0;
        load = 1; time_in = TW'(t); cycle({tag, ".load"}); load = 0;
        start = 1; cycle({tag, ".start"}); start = 0;
    endtask

    initial begin
        int done_seen;
        clear_inputs();
        rst = 1;
        model_reset();
        #1;
        check_all("reset");
        cycle("reset_hold");
        @(negedge clk);
        rst = 0;

        // 1: load 5, cook through 5 ticks, bell for 3 ticks
        load_and_start(5, "t1");
        chk("t1.rem_start", 32'(remaining), 32'd5);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick = 1; cycle("t1.tick"); tick = 0;
            done_seen += int'(done);
            cycle("t1.gap");
            done_seen += int'(done);
        end
        chk("t1.done_count", 32'(done_seen), 32'd1);
        chk("t1.bell_on", 32'(bell), 32'd1);
        for (int i = 0; i < BELL_TICKS; i++) begin
            tick = 1; cycle("t1.btick"); tick = 0;
            cycle("t1.bgap");
        end
        chk("t1.bell_off", 32'(bell), 32'd0);

        // 2: start from zero gives STEP; add_step saturates
        start = 1; cycle("t2.start"); start = 0;
        chk("t2.rem_step", 32'(remaining), 32'(STEP));
        chk("t2.heat", 32'(heat), 32'd1);
        stop = 1; cycle("t2.stop"); stop = 0;
        for (int i = 0; i < 200; i++) begin
            add_step = 1; cycle("t2.add");
        end
        add_step = 0;
        chk("t2.rem_sat", 32'(remaining), 32'(MAX_TIME));

        // 3: door with tick pauses and holds; closing alone does not resume
        load_and_start(10, "t3");
        door = 1; tick = 1; cycle("t3.door"); tick = 0;
        chk("t3.rem_hold", 32'(remaining), 32'd10);
        chk("t3.paused", 32'(heat), 32'd0);
        door = 0; cycle("t3.close"); cycle("t3.close2");
        chk("t3.still_paused", 32'(light & ~heat), 32'd1);
        start = 1; cycle("t3.resume"); start = 0;
        chk("t3.resumed", 32'(heat), 32'd1);
        chk("t3.rem_resume", 32'(remaining), 32'd10);

        // 4: last tick with add_step cancels completion
        load_and_start(1, "t4");
        tick = 1; add_step = 1; cycle("t4.tickadd"); tick = 0; add_step = 0;
        chk("t4.rem", 32'(remaining), 32'(STEP));
        chk("t4.no_done", 32'(done), 32'd0);
        chk("t4.heat", 32'(heat), 32'd1);

        // 5: door during bell opens, closing returns to idle
        load_and_start(1, "t5");
        tick = 1; cycle("t5.tick"); tick = 0;
        chk("t5.bell", 32'(bell), 32'd1);
        door = 1; cycle("t5.open");
        chk("t5.bell_off", 32'(bell), 32'd0);
        chk("t5.light", 32'(light), 32'd1);
        door = 0; cycle("t5.close");
        chk("t5.light_off", 32'(light), 32'd0);

        // 6: asynchronous reset mid-cook
        load_and_start(20, "t6");
        cycle("t6.cook");
        @(negedge clk);
        rst = 1;
        model_reset();
        #1;
        chk("t6.heat_async", 32'(heat), 32'd0);
        check_all("t6.async");
        cycle("t6.held");
        @(negedge clk);
        rst = 0;
        cycle("t6.after");

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            tick     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) door = ~door;
            start    = ($urandom_range(0, 4) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            add_step = ($urandom_range(0, 14) == 0);
            load     = ($urandom_range(0, 19) == 0);
            time_in  = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(0, 4095))
                                                    : TW'($urandom_range(0, 8));
            cycle("rand");
        end
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
